mul_div_unit: RTL and testbench

- Sequential signed multiply/divide unit for the mini SRC datapath. It sits directly downstream of the bus.
- operand_a comes from the Y register and operand_b comes from BusMuxOut.
- It produces a 64-bit result split into hi/lo, which the datapath loads into its HI and LO registers for MUL/DIV instructions.
- It handles the multi-cycle operations, so the single-cycle ALU does not have to.

---
 rtl/mini_src_pkg.sv | 17 +
 rtl/mul_div_addsub.sv | 13 +
 rtl/mul_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - shared mini SRC opcodes, mul/div state encoding and latency
package mini_src_pkg;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

   // Control unit stalls this many cycles after issuing a MUL/DIV start
   localparam int MULDIV_WIDTH   = 32;
   localparam int MULDIV_LATENCY = MULDIV_WIDTH + 2;

endpackage

// File: rtl/mul_div_addsub.sv
// rtl/mul_div_addsub.sv - shared adder/subtractor for Booth and non-restoring steps
module mul_div_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum
);

   assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - sequential signed multiply (radix-2 Booth) / divide (non-restoring)
module mul_div_unit
   import mini_src_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e        state_q, state_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH:0]   acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic             qm1_q, qm1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

   logic [WIDTH-1:0] d_mag, a_mag_in, rem_mag;
   logic [WIDTH:0]   as_a, as_b, as_sum;
   logic             as_sub;

   assign d_mag    = b_q[WIDTH-1] ? -b_q : b_q;
   assign a_mag_in = operand_a[WIDTH-1] ? -operand_a : operand_a;

   mul_div_addsub #(.W(WIDTH + 1)) u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .sum (as_sum)
   );

   // MUL keeps the Booth upper half sign-extended to WIDTH+1 so A-M never overflows
   always_comb begin
      as_a   = acc_hi_q;
      as_b   = '0;
      as_sub = 1'b0;
      if (state_q == MD_FIX) begin
         as_b = {1'b0, d_mag};
      end else if (op_q == OP_MUL) begin
         if (acc_lo_q[0] ^ qm1_q) begin
            as_b = {a_q[WIDTH-1], a_q};
         end
         as_sub = acc_lo_q[0] & ~qm1_q;
      end else begin
         as_a   = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
         as_b   = {1'b0, d_mag};
         as_sub = ~acc_hi_q[WIDTH];
      end
   end

   assign rem_mag = acc_hi_q[WIDTH] ? as_sum[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      qm1_d    = qm1_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dbz_d    = dbz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               op_d     = op;
               a_d      = operand_a;
               b_d      = operand_b;
               acc_hi_d = '0;
               acc_lo_d = (op == OP_DIV) ? a_mag_in : operand_b;
               qm1_d    = 1'b0;
               cnt_d    = '0;
               dbz_d    = 1'b0;
               busy_d   = 1'b1;
               state_d  = MD_RUN;
            end
         end
         MD_RUN: begin
            if (op_q == OP_MUL) begin
               acc_hi_d = {as_sum[WIDTH], as_sum[WIDTH:1]};
               acc_lo_d = {as_sum[0], acc_lo_q[WIDTH-1:1]};
               qm1_d    = acc_lo_q[0];
            end else begin
               acc_hi_d = as_sum;
               acc_lo_d = {acc_lo_q[WIDTH-2:0], ~as_sum[WIDTH]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = MD_FIX;
            end
         end
         MD_FIX: begin
            if (op_q == OP_MUL) begin
               hi_d = acc_hi_q[WIDTH-1:0];
               lo_d = acc_lo_q;
            end else if (b_q == '0) begin
               dbz_d = 1'b1;
               hi_d  = a_q;
               lo_d  = '1;
            end else begin
               hi_d = a_q[WIDTH-1] ? -rem_mag : rem_mag;
               lo_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc_lo_q : acc_lo_q;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = MD_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = MD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q  <= MD_IDLE;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         qm1_q    <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         qm1_q    <= qm1_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed scoreboard bench for mul_div_unit
module tb_mul_div_unit;
   import mini_src_pkg::*;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Called just after a falling edge; start is sampled at the next rising edge
   task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed);
      exp_t e;
      op = o;
      operand_a = a;
      operand_b = b;
      start = 1'b1;
      if (push) begin
         e.hi = eh;
         e.lo = el;
         e.dbz = ed;
         sb.push_back(e);
      end
      @(negedge clock);
      start = 1'b0;
   endtask

   // Entered at the falling edge of cycle 1 after the start edge
   task automatic wait_result(input string tag, input int poke);
      int   n;
      bit   busy_ok;
      exp_t e;
      n = 1;
      busy_ok = 1'b1;
      check({tag, " dbz_c1"}, {63'b0, div_by_zero}, 64'd0);
      check({tag, " done_c1"}, {63'b0, done}, 64'd0);
      while (!done && n < 100) begin
         if (!busy) busy_ok = 1'b0;
         if (n == poke) begin
            start = 1'b1;
            op = ~op;
            operand_a = $urandom;
            operand_b = $urandom;
         end
         @(negedge clock);
         start = 1'b0;
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'd34);
      check({tag, " busy_run"}, {63'b0, busy_ok}, 64'd1);
      check({tag, " busy_done"}, {63'b0, busy}, 64'd0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, " hi"}, {32'b0, hi}, {32'b0, e.hi});
         check({tag, " lo"}, {32'b0, lo}, {32'b0, e.lo});
         check({tag, " dbz"}, {63'b0, div_by_zero}, {63'b0, e.dbz});
      end else begin
         check({tag, " sb_empty"}, 64'd0, 64'd1);
      end
   endtask

   initial begin
      bit saw_done;

      clear = 1'b0;
      repeat (2) @(negedge clock);
      check("rst hi", {32'b0, hi}, 64'd0);
      check("rst lo", {32'b0, lo}, 64'd0);
      check("rst busy", {63'b0, busy}, 64'd0);
      check("rst done", {63'b0, done}, 64'd0);
      check("rst dbz", {63'b0, div_by_zero}, 64'd0);
      clear = 1'b1;

      @(negedge clock);
      launch(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      wait_result("mul 7x-3", 0);

      @(negedge clock);
      launch(OP_MUL, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0000_0000, 1'b0);
      wait_result("mul min*min", 0);

      @(negedge clock);
      launch(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_result("mul -1x1", 0);

      @(negedge clock);
      launch(OP_MUL, 32'h0000_0006, 32'h0000_0007, 1, 32'h0000_0000, 32'h0000_002A, 1'b0);
      wait_result("mul 6x7 ignore start", 5);

      @(negedge clock);
      launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      wait_result("div -7/2", 0);

      @(negedge clock);
      launch(OP_DIV, 32'd100, 32'd7, 1, 32'h0000_0002, 32'h0000_000E, 1'b0);
      wait_result("div 100/7", 0);

      @(negedge clock);
      launch(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      wait_result("div 7/-2", 0);

      @(negedge clock);
      launch(OP_DIV, 32'd100, 32'd0, 1, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
      wait_result("div 100/0", 0);

      @(negedge clock);
      check("dbz held", {63'b0, div_by_zero}, 64'd1);
      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 1'b0);
      wait_result("div min/-1", 0);

      // Start on the done cycle itself
      launch(OP_MUL, 32'hFFFF_FFFD, 32'h0000_0005, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      wait_result("mul b2b -3x5", 0);

      @(negedge clock);
      launch(OP_MUL, 32'h1234_5678, 32'h0000_0011, 0, '0, '0, 1'b0);
      for (int n = 1; n < 10; n++) begin
         if (n == 5) begin
            start = 1'b1;
            operand_a = 32'hDEAD_BEEF;
            operand_b = 32'h0000_0003;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
      end
      start = 1'b0;
      clear = 1'b0;
      @(negedge clock);
      check("abort hi", {32'b0, hi}, 64'd0);
      check("abort lo", {32'b0, lo}, 64'd0);
      check("abort busy", {63'b0, busy}, 64'd0);
      check("abort done", {63'b0, done}, 64'd0);
      clear = 1'b1;
      saw_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (done || busy) saw_done = 1'b1;
      end
      check("abort quiet", {63'b0, saw_done}, 64'd0);

      launch(OP_MUL, 32'd3, 32'd4, 1, 32'h0000_0000, 32'h0000_000C, 1'b0);
      wait_result("mul 3x4 after abort", 0);

      check("sb drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
